// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared types, defaults and saturating arithmetic for spike decoders
// Exports: CNT_W_DEFAULT, state_t {IDLE, RUN}, sat_inc(value, width).
package spike_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Increment that sticks at the all-ones value of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : (value + 32'd1);
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// rtl/spike_sat_counter.sv - saturating up-counter with clear, qualified by an enable
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   en           : cycle qualifier; counter holds when low
//   clear        : load zero (priority over inc)
//   inc          : add one, saturating at all-ones
//   count        : current value
//   count_inc    : value count would take after one saturating increment
module spike_sat_counter
    import spike_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_inc
);

    assign count_inc = W'(sat_inc(32'(count), W));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
            end else if (inc) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate and inter-spike-interval decoder
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : cycle qualifier for windowing and ISI tracking
//   spike_in     : spike train, sampled on enabled cycles
//   window_len   : window length in enabled cycles, 0 keeps decoder idle
//   out_ready    : downstream accepts the result register
//   out_valid    : result register holds an unconsumed result
//   rate_out     : spike count of the published window (saturating)
//   isi_out      : last completed inter-spike interval (saturating, 0 = none yet)
//   overrun      : one-cycle pulse when a window result was dropped
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] window_len,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate_out,
    output logic [CNT_W-1:0] isi_out,
    output logic             overrun
);

    state_t           state_q, state_next;
    logic [CNT_W-1:0] len_q, len_next;
    logic [CNT_W-1:0] pos_q, pos_next;

    logic [CNT_W-1:0] win_len_eff;
    logic             win_active;
    logic             win_last;

    logic [CNT_W-1:0] spk_cnt, spk_inc;
    logic [CNT_W-1:0] isi_cnt, isi_inc;
    logic [CNT_W-1:0] isi_last_q, isi_last_next;
    logic             seen_q;

    logic [CNT_W-1:0] cand_rate;
    logic             transfer;
    logic             load;
    logic             drop;

    // In IDLE the cycle that starts a window is its position 0, so the live
    // window_len stands in for the not-yet-latched length.
    assign win_len_eff = (state_q == IDLE) ? window_len : len_q;
    assign win_active  = enable && ((state_q == RUN) || (window_len != '0));
    assign win_last    = win_active && (pos_q == (win_len_eff - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_next;
            len_q   <= len_next;
            pos_q   <= pos_next;
        end
    end

    always_comb begin
        state_next = state_q;
        len_next   = len_q;
        pos_next   = pos_q;
        if (win_active) begin
            if (win_last) begin
                pos_next   = '0;
                len_next   = window_len;
                state_next = (window_len == '0) ? IDLE : RUN;
            end else begin
                pos_next = pos_q + CNT_W'(1);
                if (state_q == IDLE) begin
                    len_next   = window_len;
                    state_next = RUN;
                end
            end
        end
    end

    // Window spike count: held at zero outside a window and restarted after
    // the last cycle, whose spike is folded into the candidate instead.
    spike_sat_counter #(.W(CNT_W)) u_spk_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (enable),
        .clear     (!win_active || win_last),
        .inc       (spike_in),
        .count     (spk_cnt),
        .count_inc (spk_inc)
    );

    // Enabled cycles since the last spike; a spike restarts it.
    spike_sat_counter #(.W(CNT_W)) u_isi_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (enable),
        .clear     (spike_in),
        .inc       (1'b1),
        .count     (isi_cnt),
        .count_inc (isi_inc)
    );

    assign cand_rate     = spike_in ? spk_inc : spk_cnt;
    assign isi_last_next = (enable && spike_in && seen_q) ? isi_inc : isi_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            isi_last_q <= '0;
            seen_q     <= 1'b0;
        end else begin
            isi_last_q <= isi_last_next;
            if (enable && spike_in) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign transfer = out_valid && out_ready;
    assign load     = win_last && (!out_valid || transfer);
    assign drop     = win_last && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rate_out  <= '0;
            isi_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop;
            if (load) begin
                out_valid <= 1'b1;
                rate_out  <= cand_rate;
                isi_out   <= isi_last_next;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
